int_gen: RTL

INT_GEN -- requirements
Module: int_gen

---
 rtl/int_gen.sv | 118 +++++++++++
 1 files changed

// File: rtl/int_gen.sv
// Periodic / PC-match interrupt generator with pending-event counting,
// acknowledge via memory-mapped write, and a post-acknowledge holdoff window.
module int_gen #(
  parameter logic [31:0] INT_ADDR = 32'h0000_7F20,
  parameter int          PERIOD   = 200,
  parameter int          HOLDOFF  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [31:0] trig_pc,
  input  logic [31:0] macroscopic_pc,
  input  logic [31:0] m_int_addr,
  input  logic [3:0]  m_int_byteen,
  output logic        interrupt,
  output logic [2:0]  pend_cnt,
  output logic [15:0] ack_cnt,
  output logic        overflow
);

  localparam logic [15:0] PER_RELOAD = 16'(PERIOD - 1);
  localparam logic [3:0]  HOLD_LAST  = 4'(HOLDOFF - 1);

  typedef enum logic [1:0] {IDLE, ASSERT, HOLD} state_t;

  state_t      r_state;
  logic [15:0] r_per_cnt;
  logic        r_match;
  logic [3:0]  r_hold;
  logic [2:0]  r_pend;
  logic [15:0] r_ack;
  logic        r_ovf;
  logic        r_int;

  logic w_per_run;
  logic w_per_evt;
  logic w_pc_eq;
  logic w_pc_evt;
  logic w_evt;
  logic w_ack;

  assign w_per_run = en & mode[0];
  assign w_per_evt = w_per_run & (r_per_cnt == 16'd0);
  assign w_pc_eq   = (macroscopic_pc == trig_pc);
  // Only the first cycle of a match fires, so a stalled PC yields one event.
  assign w_pc_evt  = en & mode[1] & w_pc_eq & ~r_match;
  assign w_evt     = w_per_evt | w_pc_evt;
  assign w_ack     = (r_state == ASSERT) & (m_int_addr == INT_ADDR) & (|m_int_byteen);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_per_cnt <= PER_RELOAD;
      r_match   <= 1'b0;
    end else begin
      r_match <= w_pc_eq;
      if (!w_per_run || r_per_cnt == 16'd0) r_per_cnt <= PER_RELOAD;
      else                                  r_per_cnt <= r_per_cnt - 16'd1;
    end
  end

  // Event and acknowledge on the same edge cancel out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend <= 3'd0;
      r_ovf  <= 1'b0;
    end else if (w_evt && !w_ack) begin
      if (r_pend == 3'd7) r_ovf  <= 1'b1;
      else                r_pend <= r_pend + 3'd1;
    end else if (w_ack && !w_evt) begin
      r_pend <= r_pend - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_int   <= 1'b0;
      r_hold  <= 4'd0;
      r_ack   <= 16'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_pend != 3'd0) begin
            r_state <= ASSERT;
            r_int   <= 1'b1;
          end
        end
        ASSERT: begin
          if (w_ack) begin
            r_state <= HOLD;
            r_int   <= 1'b0;
            r_hold  <= 4'd0;
            r_ack   <= r_ack + 16'd1;
          end
        end
        HOLD: begin
          if (r_hold == HOLD_LAST) begin
            r_state <= IDLE;
            r_hold  <= 4'd0;
          end else begin
            r_hold <= r_hold + 4'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_int   <= 1'b0;
        end
      endcase
    end
  end

  assign interrupt = r_int;
  assign pend_cnt  = r_pend;
  assign ack_cnt   = r_ack;
  assign overflow  = r_ovf;

endmodule
